// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C target bridge
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT
  } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - two-flop synchronizer with rise/fall detect for a bus pin
module i2c_sync_edge (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  // Reset to the idle-high bus level so no edge is seen when reset releases.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      meta <= 1'b1;
      q    <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
    end
  end

  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/i2c_slave_bridge.sv
// rtl/i2c_slave_bridge.sv - I2C target that turns bus transfers into register reads/writes
module i2c_slave_bridge
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLV_ADDR = 7'h50,
  parameter int                    PTR_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic                  wr_en,
  output logic [PTR_W-1:0]      wr_addr,
  output logic [I2C_BYTE_W-1:0] wr_data,
  output logic [PTR_W-1:0]      rd_addr,
  input  logic [I2C_BYTE_W-1:0] rd_data,
  output logic                  busy
);

  logic scl_q, scl_rise, scl_fall;
  logic sda_q, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_state_e            state;
  logic [3:0]            bit_cnt;
  logic [I2C_BYTE_W-1:0] shreg;
  logic                  rw;
  logic [PTR_W-1:0]      ptr;
  logic                  inc_ptr;

  i2c_sync_edge u_scl (.clk(clk), .rst_b(rst_b), .d(scl_i), .q(scl_q), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge u_sda (.clk(clk), .rst_b(rst_b), .d(sda_i), .q(sda_q), .rise(sda_rise), .fall(sda_fall));

  // SCL high in both samples is scl_q with no rising edge this cycle.
  assign start_det = sda_fall & scl_q & ~scl_rise;
  assign stop_det  = sda_rise & scl_q & ~scl_rise;

  assign rd_addr = ptr;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      rw      <= 1'b0;
      ptr     <= '0;
      inc_ptr <= 1'b0;
      sda_oe  <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      inc_ptr <= 1'b0;
      if (inc_ptr) ptr <= ptr + PTR_W'(1);

      if (stop_det) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
      end else if (start_det) begin
        state   <= ADDR;
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            // bit_cnt[3] marks a complete byte waiting for the ACK-driving fall.
            if (scl_rise && !bit_cnt[3]) begin
              shreg   <= {shreg[I2C_BYTE_W-2:0], sda_q};
              bit_cnt <= bit_cnt + 4'd1;
              if (state == ADDR && bit_cnt == 4'd7) begin
                rw <= sda_q;
                if (shreg[I2C_ADDR_W-1:0] != SLV_ADDR) state <= WAIT;
              end
            end else if (scl_fall && bit_cnt[3]) begin
              sda_oe  <= 1'b1;
              bit_cnt <= '0;
              if (state == ADDR) begin
                busy  <= 1'b1;
                state <= ADDR_ACK;
              end else if (state == PTR) begin
                ptr   <= PTR_W'(shreg);
                state <= PTR_ACK;
              end else begin
                wr_en   <= 1'b1;
                wr_addr <= ptr;
                wr_data <= shreg;
                inc_ptr <= 1'b1;
                state   <= WDATA_ACK;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (rw == I2C_RW_READ) begin
                shreg  <= rd_data;
                sda_oe <= ~rd_data[I2C_BYTE_W-1];
                state  <= RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= PTR;
              end
            end
          end
          PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= WDATA;
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= RDATA_ACK;
              end else begin
                shreg   <= {shreg[I2C_BYTE_W-2:0], 1'b0};
                sda_oe  <= ~shreg[I2C_BYTE_W-2];
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          RDATA_ACK: begin
            // Every transmitted byte advances the pointer; only an ACK continues the read.
            if (scl_rise && !bit_cnt[3]) begin
              inc_ptr <= 1'b1;
              if (sda_q == I2C_ACK) bit_cnt <= 4'd8;
              else                  state   <= WAIT;
            end else if (scl_fall && bit_cnt[3]) begin
              shreg   <= rd_data;
              sda_oe  <= ~rd_data[I2C_BYTE_W-1];
              bit_cnt <= '0;
              state   <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_bridge.sv
// tb/tb_i2c_slave_bridge.sv - directed bus-master bench for i2c_slave_bridge
module tb_i2c_slave_bridge;
  import i2c_pkg::*;

  localparam int CLK_P = 10;
  localparam int Q     = 5;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  wire        sda_bus = sda_m & ~sda_oe;

  int tests_run = 0;
  int tests_failed = 0;

  always #(CLK_P/2) clk = ~clk;

  assign rd_data = rd_addr ^ 8'hFF;

  i2c_slave_bridge #(.SLV_ADDR(7'h50), .PTR_W(8)) dut (
    .clk(clk), .rst_b(rst_b), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_oe(sda_oe), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  // Observers: write log, sda_oe timing relative to the pad SCL fall.
  logic [15:0] wq[$];
  time         t_fall = 0;
  logic        mon_en = 1'b0;
  logic        last_oe = 1'b0;
  int          oe_hi = 0, busy_hi = 0, oe_changes = 0, oe_viol = 0;

  always @(negedge clk) begin
    if (wr_en) wq.push_back({wr_addr, wr_data});
    if (sda_oe) oe_hi <= oe_hi + 1;
    if (busy) busy_hi <= busy_hi + 1;
    if (mon_en && rst_b && sda_oe !== last_oe) begin
      oe_changes <= oe_changes + 1;
      if (scl_m || ($time - t_fall) > 4 * CLK_P) oe_viol <= oe_viol + 1;
    end
    last_oe <= sda_oe;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int wr_idx = 0;
  task automatic check_wr(input string tag, input logic [7:0] a, input logic [7:0] d);
    logic [31:0] got;
    got = (wr_idx < wq.size()) ? {16'h0, wq[wr_idx]} : 32'hFFFF_FFFF;
    check(tag, got, {16'h0, a, d});
    wr_idx++;
  endtask

  task automatic tick();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic scl_low();
    scl_m = 1'b0;
    t_fall = $time;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; tick();
    sda_m = 1'b0; tick();
    scl_low(); tick();
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; tick();
    scl_m = 1'b1; tick();
    sda_m = 1'b0; tick();
    scl_low(); tick();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick();
    scl_m = 1'b1; tick();
    sda_m = 1'b1; tick(); tick();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; tick();
    scl_m = 1'b1; tick(); tick();
    scl_low(); tick();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick();
    scl_m = 1'b1; tick();
    b = sda_bus; tick();
    scl_low(); tick();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(ack);
  endtask

  logic       ack;
  logic [7:0] rd;
  int         snap_oe, snap_busy, snap_wq;

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_busy", busy, 0);
    rst_b = 1'b1;
    tick();
    mon_en = 1'b1;

    // Plain write with auto-increment.
    i2c_start();
    write_byte(8'hA0, ack); check("wr_ack_addr", ack, 0);
    check("wr_busy_mid", busy, 1);
    write_byte(8'h10, ack); check("wr_ack_ptr", ack, 0);
    write_byte(8'h5A, ack); check("wr_ack_d0", ack, 0);
    write_byte(8'hC3, ack); check("wr_ack_d1", ack, 0);
    i2c_stop();
    check("wr_count", wq.size(), 2);
    check_wr("wr_0", 8'h10, 8'h5A);
    check_wr("wr_1", 8'h11, 8'hC3);
    check("wr_busy_after_stop", busy, 0);
    check("wr_ptr_after", rd_addr, 8'h12);

    // Pointer set, repeated START, read three bytes.
    i2c_start();
    write_byte(8'hA0, ack); check("rd_ack_addr", ack, 0);
    write_byte(8'h20, ack); check("rd_ack_ptr", ack, 0);
    i2c_rstart();
    write_byte(8'hA1, ack); check("rd_ack_raddr", ack, 0);
    read_byte(1'b0, rd); check("rd_byte0", rd, 8'hDF);
    read_byte(1'b0, rd); check("rd_byte1", rd, 8'hDE);
    read_byte(1'b1, rd); check("rd_byte2", rd, 8'hDD);
    i2c_stop();
    check("rd_ptr_end", rd_addr, 8'h23);
    check("rd_no_writes", wq.size(), 2);

    // Foreign address is ignored entirely.
    snap_oe = oe_hi; snap_busy = busy_hi; snap_wq = wq.size();
    i2c_start();
    write_byte(8'hB0, ack); check("mm_nack_addr", ack, 1);
    write_byte(8'h10, ack); check("mm_nack_d0", ack, 1);
    write_byte(8'h55, ack); check("mm_nack_d1", ack, 1);
    i2c_stop();
    check("mm_oe_never", oe_hi - snap_oe, 0);
    check("mm_busy_never", busy_hi - snap_busy, 0);
    check("mm_no_writes", wq.size() - snap_wq, 0);

    // Pointer wraps from 0xFF to 0x00.
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h01, ack); check("wrap_ack_d0", ack, 0);
    write_byte(8'h02, ack); check("wrap_ack_d1", ack, 0);
    i2c_stop();
    check_wr("wrap_0", 8'hFF, 8'h01);
    check_wr("wrap_1", 8'h00, 8'h02);

    // STOP in the middle of a data byte.
    snap_wq = wq.size();
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h30, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
    i2c_stop();
    check("abort_no_write", wq.size() - snap_wq, 0);
    check("abort_busy", busy, 0);

    // Asynchronous reset while the address ACK is driven.
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 5);
    sda_m = 1'b1; tick();
    scl_m = 1'b1; tick();
    check("abort_ack_driven", sda_oe, 1);
    mon_en = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("abort_rst_oe", sda_oe, 0);
    check("abort_rst_busy", busy, 0);
    check("abort_rst_state", 32'(dut.state), 32'(IDLE));
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b1;
    tick(); tick();
    mon_en = 1'b1;
    check("abort_rst_no_write", wq.size() - snap_wq, 0);

    i2c_start();
    write_byte(8'hA0, ack); check("post_rst_ack", ack, 0);
    write_byte(8'h05, ack);
    write_byte(8'h99, ack);
    i2c_stop();
    check_wr("post_rst_wr", 8'h05, 8'h99);

    check("timing_oe_changes_seen", oe_changes > 20, 1);
    check("timing_oe_violations", oe_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
